// File: rtl/add_pkg.sv
// Shared sizing constants and types for the 32-bit carry-lookahead adder.
package add_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int CLA_GROUP  = 4;
    localparam int NUM_GROUPS = ADD_WIDTH / CLA_GROUP;

    typedef logic [ADD_WIDTH-1:0] word_t;

endpackage : add_pkg

// File: rtl/add4_cla.sv
// 4-bit carry-lookahead group: sum and carry-out from one-level lookahead on c0,
// plus group generate/propagate for a future second lookahead level.
module add4_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       g_grp,
    output logic       p_grp
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Every carry is a flat sum of products on c0; nothing ripples inside the group.
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
        c4    = g_grp | (p_grp & c0);

        s = p ^ {c3, c2, c1, c0};
    end

endmodule : add4_cla

// File: rtl/add_32.sv
// 32-bit adder built from cascaded 4-bit lookahead groups, gated by the add strobe.
// Purely combinational; clock and reset exist only for a uniform module shell.
module add_32
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             add,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = WIDTH / GROUP;

    logic [NGRP:0]    carry;
    logic [WIDTH-1:0] raw_sum;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;

    // Shell ports and reserved group G/P have no consumer yet.
    logic unused_sigs;
    assign unused_sigs = ^{m_clock, p_reset, grp_g, grp_p};

    assign carry[0] = cin;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
        add4_cla u_cla (
            .a     (a[gi*GROUP +: GROUP]),
            .b     (b[gi*GROUP +: GROUP]),
            .c0    (carry[gi]),
            .s     (raw_sum[gi*GROUP +: GROUP]),
            .c4    (carry[gi+1]),
            .g_grp (grp_g[gi]),
            .p_grp (grp_p[gi])
        );
    end

    // With add low the outputs are forced to a known zero even if operands are X.
    always_comb begin
        sum  = '0;
        cout = 1'b0;
        if (add) begin
            sum  = raw_sum;
            cout = carry[NGRP];
        end
    end

endmodule : add_32

// File: tb/tb_add_32.sv
// Directed and table-driven bench for add_32 with a 33-bit reference sum.
module tb_add_32;

    logic        m_clock;
    logic        p_reset;
    logic        add;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int n_vec  = 0;
    int n_miss = 0;

    add_32 dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .add     (add),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic chk(input string tag, input logic [31:0] exp_sum, input logic exp_cout);
        n_vec++;
        assert (sum === exp_sum && cout === exp_cout) else begin
            n_miss++;
            $error("FAIL %s: got sum=%h cout=%b, want sum=%h cout=%b",
                   tag, sum, cout, exp_sum, exp_cout);
        end
    endtask

    task automatic drive(input logic ad, input logic [31:0] av, input logic [31:0] bv,
                         input logic c);
        @(posedge m_clock);
        #1;
        add = ad;
        a   = av;
        b   = bv;
        cin = c;
        #3;
    endtask

    initial begin
        logic [32:0] ref33;
        logic [31:0] va;
        logic [31:0] vb;
        logic        vc;

        p_reset = 1'b1;
        add = 1'b0;
        a = 32'h0;
        b = 32'h0;
        cin = 1'b0;

        // Reset asserted, add low: outputs are zero.
        drive(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1);
        chk("reset_idle", 32'h0, 1'b0);

        // Reset has no effect on the datapath.
        drive(1'b1, 32'd5, 32'd7, 1'b1);
        chk("reset_add", 32'd13, 1'b0);

        p_reset = 1'b0;

        drive(1'b1, 32'h00000001, 32'h00000001, 1'b0);
        chk("one_plus_one", 32'h00000002, 1'b0);

        drive(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        chk("full_ripple", 32'h00000000, 1'b1);

        drive(1'b1, 32'h80000000, 32'h80000000, 1'b0);
        chk("msb_carry", 32'h00000000, 1'b1);

        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        chk("wrap_all_ones", 32'hFFFFFFFF, 1'b1);

        drive(1'b1, 32'h0000000F, 32'h00000001, 1'b0);
        chk("group0_carry", 32'h00000010, 1'b0);

        drive(1'b1, 32'h0FFFFFFF, 32'h00000000, 1'b1);
        chk("ripple_7_groups", 32'h10000000, 1'b0);

        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b0);
        chk("alt_no_cin", 32'hFFFFFFFF, 1'b0);

        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1);
        chk("alt_cin", 32'h00000000, 1'b1);

        drive(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        chk("gated_off", 32'h00000000, 1'b0);

        // Raise add with no clock edge in between: result appears combinationally.
        #1;
        add = 1'b1;
        #1;
        chk("gated_on_same_cycle", 32'hACF13569, 1'b0);

        // Unknown operands with add low must still yield a clean zero.
        drive(1'b0, 32'hxxxxxxxx, 32'hxxxxxxxx, 1'bx);
        chk("x_gated_off", 32'h00000000, 1'b0);

        // 4000 vectors: random plus all-ones, all-zeros and alternating patterns.
        for (int i = 0; i < 4000; i++) begin
            case (i % 8)
                0: begin va = 32'hFFFFFFFF; vb = $urandom;      end
                1: begin va = 32'h00000000; vb = $urandom;      end
                2: begin va = 32'hAAAAAAAA; vb = 32'h55555555;  end
                3: begin va = 32'h55555555; vb = $urandom;      end
                4: begin va = $urandom;     vb = 32'hFFFFFFFF;  end
                5: begin va = $urandom;     vb = ~va;           end
                default: begin va = $urandom; vb = $urandom;    end
            endcase
            vc = 1'($urandom_range(0, 1));
            ref33 = {1'b0, va} + {1'b0, vb} + {32'h0, vc};
            drive(1'b1, va, vb, vc);
            chk($sformatf("vec%0d", i), ref33[31:0], ref33[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_add_32
